// File: rtl/add_sub_checker.sv
// Scoreboard for an 8-bit add/sub DUT: reference model with accumulator, a
// LATENCY-deep pipeline of expected results, and pass/error bookkeeping.
//
// state | meaning
// IDLE  | waiting for start; in_valid and DUT outputs ignored
// RUN   | model tracks in_valid, compares happen as entries emerge
// HALT  | err_cnt reached MAX_ERR; counters frozen until start
module add_sub_checker #(
  parameter int LATENCY = 1,
  parameter int MAX_ERR = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        Sel,
  input  logic        AddSub,
  input  logic [7:0]  dut_Z,
  input  logic        dut_Carryout,
  input  logic        dut_Overflow,
  output logic [15:0] pass_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_idx,
  output logic        mismatch,
  output logic        err_sticky,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

  localparam logic [15:0] MAX_ERR_W = 16'(MAX_ERR);

  state_e             state_q, state_d;
  logic [7:0]         acc_q, acc_d;
  logic [15:0]        idx_q, idx_d;
  logic [15:0]        pass_q, pass_d;
  logic [15:0]        err_q, err_d;
  logic [15:0]        fidx_q, fidx_d;
  logic               sticky_q, sticky_d;
  logic               mismatch_q, mismatch_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [9:0]         exp_q [LATENCY];
  logic [9:0]         exp_d [LATENCY];
  logic [15:0]        tag_q [LATENCY];
  logic [15:0]        tag_d [LATENCY];

  logic [7:0] op1;
  logic [8:0] res9;
  logic       model_v;
  logic       accept;
  logic       cmp_en;
  logic       cmp_ok;

  // Reference model: the 9th bit of the subtraction is the borrow (op1 < B).
  always_comb begin
    op1  = Sel ? acc_q : A;
    res9 = AddSub ? ({1'b0, op1} - {1'b0, B}) : ({1'b0, op1} + {1'b0, B});
    if (AddSub) begin
      model_v = (op1[7] != B[7]) && (res9[7] != op1[7]);
    end else begin
      model_v = (op1[7] == B[7]) && (res9[7] != op1[7]);
    end
  end

  assign accept = (state_q == ST_RUN) && in_valid && !start;
  assign cmp_en = (state_q == ST_RUN) && vld_q[LATENCY-1] && !start;
  assign cmp_ok = ({dut_Z, dut_Carryout, dut_Overflow} == exp_q[LATENCY-1]);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fidx_d     = fidx_q;
    sticky_d   = sticky_q;
    mismatch_d = 1'b0;
    vld_d      = vld_q;
    exp_d      = exp_q;
    tag_d      = tag_q;

    vld_d[0] = accept;
    exp_d[0] = {res9[7:0], res9[8], model_v};
    tag_d[0] = idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    if (start) begin
      state_d  = ST_RUN;
      acc_d    = '0;
      idx_d    = '0;
      pass_d   = '0;
      err_d    = '0;
      fidx_d   = '0;
      sticky_d = 1'b0;
      vld_d    = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            acc_d = res9[7:0];
            idx_d = idx_q + 16'd1;
          end
          if (cmp_en) begin
            if (cmp_ok) begin
              pass_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
            end else begin
              err_d      = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
              mismatch_d = 1'b1;
              if (!sticky_q) begin
                sticky_d = 1'b1;
                fidx_d   = tag_q[LATENCY-1];
              end
              // The halting compare itself is counted; everything behind it is dropped.
              if (err_d >= MAX_ERR_W) begin
                state_d = ST_HALT;
                vld_d   = '0;
              end
            end
          end
        end
        default: vld_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      err_q      <= '0;
      fidx_q     <= '0;
      sticky_q   <= 1'b0;
      mismatch_q <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        exp_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fidx_q     <= fidx_d;
      sticky_q   <= sticky_d;
      mismatch_q <= mismatch_d;
      vld_q      <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        exp_q[i] <= exp_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign pass_cnt      = pass_q;
  assign err_cnt       = err_q;
  assign first_err_idx = fidx_q;
  assign mismatch      = mismatch_q;
  assign err_sticky    = sticky_q;
  assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_add_sub_checker.sv
// Directed bench for add_sub_checker: one instance at LATENCY=1/MAX_ERR=16,
// one at LATENCY=3/MAX_ERR=2, sharing clock, reset and operand buses.
module tb_add_sub_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A, B;
  logic        Sel, AddSub;

  logic        start1, iv1, c1, v1;
  logic [7:0]  z1;
  logic [15:0] pc1, ec1, fi1;
  logic        mm1, es1, bz1;

  logic        start3, iv3, c3, v3;
  logic [7:0]  z3;
  logic [15:0] pc3, ec3, fi3;
  logic        mm3, es3, bz3;

  int vectors     = 0;
  int miscompares = 0;
  int mm1_seen    = 0;
  int mm3_seen    = 0;
  int base;

  add_sub_checker #(.LATENCY(1), .MAX_ERR(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(iv1),
    .A(A), .B(B), .Sel(Sel), .AddSub(AddSub),
    .dut_Z(z1), .dut_Carryout(c1), .dut_Overflow(v1),
    .pass_cnt(pc1), .err_cnt(ec1), .first_err_idx(fi1),
    .mismatch(mm1), .err_sticky(es1), .busy(bz1)
  );

  add_sub_checker #(.LATENCY(3), .MAX_ERR(2)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(iv3),
    .A(A), .B(B), .Sel(Sel), .AddSub(AddSub),
    .dut_Z(z3), .dut_Carryout(c3), .dut_Overflow(v3),
    .pass_cnt(pc3), .err_cnt(ec3), .first_err_idx(fi3),
    .mismatch(mm3), .err_sticky(es3), .busy(bz3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mm1) mm1_seen++;
    if (mm3) mm3_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic sub);
    A = a; B = b; Sel = s; AddSub = sub;
  endtask

  task automatic res1(input logic [7:0] z, input logic c, input logic v);
    z1 = z; c1 = c; v1 = v;
  endtask

  task automatic res3(input logic [7:0] z, input logic c, input logic v);
    z3 = z; c3 = c; v3 = v;
  endtask

  initial begin
    rst_n = 1'b0;
    A = 8'd0; B = 8'd0; Sel = 1'b0; AddSub = 1'b0;
    start1 = 1'b0; iv1 = 1'b0; z1 = 8'd0; c1 = 1'b0; v1 = 1'b0;
    start3 = 1'b0; iv3 = 1'b0; z3 = 8'd0; c3 = 1'b0; v3 = 1'b0;
    #3;
    chk16("rst_pass_cnt", pc1, 16'd0);
    chk16("rst_err_cnt", ec1, 16'd0);
    chk16("rst_first_idx", fi1, 16'd0);
    chk1("rst_mismatch", mm1, 1'b0);
    chk1("rst_sticky", es1, 1'b0);
    chk1("rst_busy", bz1, 1'b0);
    #9 rst_n = 1'b1;
    tick();
    chk1("idle_after_rst", bz1, 1'b0);

    // Single add, correct DUT
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk1("busy_after_start", bz1, 1'b1);
    base = mm1_seen;
    op(8'd25, 8'd10, 1'b0, 1'b0); iv1 = 1'b1; tick();
    iv1 = 1'b0; res1(8'd35, 1'b0, 1'b0); tick();
    chk16("add_pass_cnt", pc1, 16'd1);
    chk16("add_err_cnt", ec1, 16'd0);
    tick();
    chk16("add_no_mismatch", 16'(mm1_seen - base), 16'd0);

    // Accumulate chain back-to-back: 40-15=25, ACC+5=30, ACC-3=27
    start1 = 1'b1; tick(); start1 = 1'b0;
    op(8'd40, 8'd15, 1'b0, 1'b1); iv1 = 1'b1; tick();
    op(8'd200, 8'd5, 1'b1, 1'b0); res1(8'd25, 1'b0, 1'b0); tick();
    op(8'd200, 8'd3, 1'b1, 1'b1); res1(8'd30, 1'b0, 1'b0); tick();
    iv1 = 1'b0; res1(8'd27, 1'b0, 1'b0); tick();
    chk16("acc_pass_cnt", pc1, 16'd3);
    chk16("acc_err_cnt", ec1, 16'd0);

    // Flag cases: signed overflow, borrow, unsigned carry
    start1 = 1'b1; tick(); start1 = 1'b0;
    op(8'd100, 8'd50, 1'b0, 1'b0); iv1 = 1'b1; tick();
    op(8'd5, 8'd10, 1'b0, 1'b1); res1(8'd150, 1'b0, 1'b1); tick();
    op(8'd200, 8'd100, 1'b0, 1'b0); res1(8'd251, 1'b1, 1'b0); tick();
    iv1 = 1'b0; res1(8'd44, 1'b1, 1'b0); tick();
    chk16("flags_pass_cnt", pc1, 16'd3);
    chk16("flags_err_cnt", ec1, 16'd0);

    // First mismatch at transaction 0, later error keeps index 0
    start1 = 1'b1; tick(); start1 = 1'b0;
    op(8'd25, 8'd10, 1'b0, 1'b0); iv1 = 1'b1; tick();
    iv1 = 1'b0; res1(8'd36, 1'b0, 1'b0); tick();
    chk1("err_mismatch_pulse", mm1, 1'b1);
    chk16("err_cnt_1", ec1, 16'd1);
    chk16("err_first_idx", fi1, 16'd0);
    chk1("err_sticky", es1, 1'b1);
    op(8'd1, 8'd1, 1'b0, 1'b0); iv1 = 1'b1; tick();
    chk1("err_mismatch_one_cycle", mm1, 1'b0);
    op(8'd3, 8'd4, 1'b0, 1'b0); res1(8'd2, 1'b0, 1'b0); tick();
    iv1 = 1'b0; res1(8'd0, 1'b0, 1'b0); tick();
    chk16("err_cnt_2", ec1, 16'd2);
    chk16("err_pass_cnt", pc1, 16'd1);
    chk16("err_first_idx_held", fi1, 16'd0);
    chk1("err_mismatch_second", mm1, 1'b1);

    // start clears sticky state and beats a coincident compare
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk1("start_clears_sticky", es1, 1'b0);
    chk16("start_clears_err", ec1, 16'd0);
    op(8'd25, 8'd10, 1'b0, 1'b0); iv1 = 1'b1; tick();
    iv1 = 1'b0; res1(8'd36, 1'b0, 1'b0); start1 = 1'b1; tick(); start1 = 1'b0;
    chk16("start_wins_err", ec1, 16'd0);
    chk1("start_wins_mismatch", mm1, 1'b0);
    tick();
    chk16("start_wins_flushed", ec1, 16'd0);
    chk16("start_wins_pass", pc1, 16'd0);

    // LATENCY=3, MAX_ERR=2: three bad results, halt after second
    start3 = 1'b1; tick(); start3 = 1'b0;
    op(8'd1, 8'd1, 1'b0, 1'b0); iv3 = 1'b1; tick();
    tick();
    tick();
    iv3 = 1'b0; res3(8'd0, 1'b0, 1'b0); tick();
    chk16("halt_err_cnt_1", ec3, 16'd1);
    chk1("halt_still_busy", bz3, 1'b1);
    tick();
    chk16("halt_err_cnt_2", ec3, 16'd2);
    chk1("halt_busy_low", bz3, 1'b0);
    tick();
    chk1("halt_third_ignored", mm3, 1'b0);
    chk16("halt_err_cnt_held", ec3, 16'd2);
    chk16("halt_pass_cnt", pc3, 16'd0);

    // Reset with two compares in flight
    start3 = 1'b1; tick(); start3 = 1'b0;
    op(8'd1, 8'd1, 1'b0, 1'b0); iv3 = 1'b1; tick();
    tick();
    tick();
    iv3 = 1'b0; res3(8'd0, 1'b0, 1'b0); tick();
    chk1("pre_rst_mismatch", mm3, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_rst_mismatch", mm3, 1'b0);
    chk16("async_rst_err_cnt", ec3, 16'd0);
    chk1("async_rst_sticky", es3, 1'b0);
    chk1("async_rst_busy", bz3, 1'b0);
    base = mm3_seen;
    tick();
    #2 rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk16("post_rst_no_mismatch", 16'(mm3_seen - base), 16'd0);
    chk16("post_rst_err_cnt", ec3, 16'd0);
    chk1("post_rst_idle", bz3, 1'b0);
    start3 = 1'b1; tick(); start3 = 1'b0;
    chk1("resume_busy", bz3, 1'b1);
    op(8'd7, 8'd9, 1'b0, 1'b1); iv3 = 1'b1; tick();
    iv3 = 1'b0; tick();
    tick();
    res3(8'd254, 1'b1, 1'b0); tick();
    chk16("resume_pass_cnt", pc3, 16'd1);
    chk16("resume_err_cnt", ec3, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_sub_checker.md
ADD_SUB_CHECKER -- requirements
Module: add_sub_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 1, cycles from operand issue to DUT result (legal 1..4).
REQ-002 SHALL have parameter MAX_ERR, default 16, error count at which checking halts.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse: clear counters and model, enter RUN.
REQ-006 in_valid  input  1  operand set on A/B/Sel/AddSub issued to DUT this cycle.
REQ-007 A, B  input  8 each  operands as driven to DUT.
REQ-008 Sel  input  1  0 = A op B; 1 = accumulate, ACC op B (A ignored).
REQ-009 AddSub  input  1  0 = add, 1 = subtract.
REQ-010 dut_Z  input  8  DUT result.
REQ-011 dut_Carryout, dut_Overflow  input  1 each  DUT flags.
REQ-012 pass_cnt, err_cnt  output  16 each  matched / mismatched transaction counts.
REQ-013 first_err_idx  output  16  transaction index (0-based) of first mismatch.
REQ-014 mismatch  output  1  one-cycle pulse per failing compare.
REQ-015 err_sticky  output  1  set at first mismatch, held until start or reset.
REQ-016 busy  output  1  high in RUN.

Function
REQ-017 FSM SHALL have states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT when err_cnt reaches MAX_ERR; start from any state -> RUN with counters, index, ACC, err_sticky, first_err_idx cleared and delay line flushed.
REQ-018 In IDLE and HALT, in_valid and DUT outputs SHALL be ignored; counters hold.
REQ-019 Reference model computes at in_valid: op1 = Sel ? ACC : A; add: {C,R} = op1 + B (9-bit); sub: R = op1 - B mod 256, C = 1 when op1 < B unsigned (borrow).
REQ-020 V SHALL be signed overflow: add, op1[7]==B[7] and R[7]!=op1[7]; sub, op1[7]!=B[7] and R[7]!=op1[7].
REQ-021 ACC (8-bit, model-owned) SHALL update to R on every accepted in_valid, regardless of Sel; DUT result never feeds ACC.
REQ-022 Expected {R,C,V} plus valid bit and transaction index SHALL pass through a LATENCY-deep shift register; compare occurs in the cycle the valid bit emerges.
REQ-023 Compare: all of Z, Carryout, Overflow equal -> pass_cnt+1; else err_cnt+1, mismatch=1 that cycle.
REQ-024 First mismatch since start SHALL latch first_err_idx and set err_sticky; later mismatches leave first_err_idx unchanged.
REQ-025 Transaction index increments per accepted in_valid, wraps 16'hFFFF -> 0.
REQ-026 pass_cnt and err_cnt SHALL saturate at 16'hFFFF.
REQ-027 Back-to-back in_valid every cycle SHALL be supported with no lost compares.
REQ-028 Compare emerging in the same cycle as entering HALT SHALL be counted; in-flight entries behind it are discarded.
REQ-029 start coincident with an emerging compare: start wins, compare discarded.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, ACC=0, delay line invalid, all outputs 0.
REQ-031 Reset mid-RUN SHALL discard in-flight compares; after release, block stays IDLE until start.

Verification
REQ-032 start; A=25,B=10,Sel=0,AddSub=0; DUT Z=35,C=0,V=0 at LATENCY -> pass_cnt=1, err_cnt=0, mismatch never high.
REQ-033 Sequence 40-15 (Sel=0), then Sel=1 +5, then Sel=1 -3, correct DUT -> expected Z 25, 30, 27; pass_cnt=3.
REQ-034 A=100,B=50 add -> expected Z=150,C=0,V=1; A=5,B=10 sub -> Z=251,C=1,V=0; correct DUT -> both pass.
REQ-035 25+10 with DUT Z=36 as transaction 0 -> mismatch pulse one cycle, err_cnt=1, first_err_idx=0, err_sticky=1; later errors keep idx 0.
REQ-036 MAX_ERR=2, three consecutive bad results -> HALT after second, err_cnt=2, busy=0, third ignored.
REQ-037 rst_n low with two compares in flight (LATENCY=3) -> all outputs 0 asynchronously, no mismatch after release, start required to resume.
